// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - shared types and frame constants for the SD CMD-line responder
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_WAIT_RSP,
    ST_NCR,
    ST_TX
  } state_t;

  localparam int         CMD_FRAME_BITS = 48;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  // Bit positions within a frame, counted from the start bit (bit 0), MSB first
  localparam int BIT_TRANS = 1;
  localparam int BIT_INDEX = 2;
  localparam int BIT_ARG   = 8;
  localparam int BIT_CRC   = 40;
  localparam int BIT_END   = CMD_FRAME_BITS - 1;

  localparam logic TRANS_HOST = 1'b1;
  localparam logic TRANS_CARD = 1'b0;

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1) with clear, update and shift-out modes
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       shift,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  always_comb fb = bit_in ^ crc[6];

  // Shift-out mode moves the finished remainder MSB-first to crc[6]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (shift) begin
      crc <= {crc[5:0], 1'b0};
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line: command deserialiser and response serialiser
// Optional receive CRC check: SD_CMD_RSP_CRC_CHECK_EN
module sd_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        frame_err,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg,
  input  logic        rsp_drop,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TRANS    = CNT_W'(BIT_TRANS);
  localparam logic [CNT_W-1:0] CNT_INDEX    = CNT_W'(BIT_INDEX);
  localparam logic [CNT_W-1:0] CNT_CRC      = CNT_W'(BIT_CRC);
  localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(BIT_END);
  localparam logic [CNT_W-1:0] CNT_NCR_LAST = CNT_W'(NCR_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [37:0]      rx_sr;
  logic [39:0]      tx_sr;
  logic [6:0]       crc;
  logic             crc_clear, crc_en, crc_shift, crc_bit;
  logic             in_body, rx_end, rx_good, rsp_take, trans_bad;

  always_comb begin
    in_body   = bit_cnt < CNT_CRC;
    rx_end    = (state == ST_RX) && (bit_cnt == CNT_END);
    rx_good   = rx_end && cmd_in;
    trans_bad = (state == ST_RX) && (bit_cnt == CNT_TRANS) && (cmd_in != TRANS_HOST);
    rsp_take  = (state == ST_WAIT_RSP) && !rsp_drop && rsp_valid;
  end

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    cmd_oe     = 1'b0;
    cmd_out    = 1'b1;
    rsp_ready  = 1'b0;
    busy       = (state != ST_IDLE);
    unique case (state)
      ST_IDLE: begin
        if (!cmd_in) begin
          state_nx   = ST_RX;
          bit_cnt_nx = CNT_ONE;
        end
      end
      ST_RX: begin
        if (trans_bad) begin
          state_nx = ST_IDLE;
        end else if (bit_cnt == CNT_END) begin
          state_nx = cmd_in ? ST_WAIT_RSP : ST_IDLE;
        end else begin
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        rsp_ready = 1'b1;
        if (rsp_drop) begin
          state_nx = ST_IDLE;
        end else if (rsp_valid) begin
          state_nx   = ST_NCR;
          bit_cnt_nx = '0;
        end else if (!cmd_in) begin
          state_nx   = ST_RX;
          bit_cnt_nx = CNT_ONE;
        end
      end
      ST_NCR: begin
        if (bit_cnt == CNT_NCR_LAST) begin
          state_nx   = ST_TX;
          bit_cnt_nx = '0;
        end else begin
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      ST_TX: begin
        cmd_oe = 1'b1;
        if (in_body) begin
          cmd_out = tx_sr[39];
        end else if (bit_cnt != CNT_END) begin
          cmd_out = crc[6];
        end
        if (bit_cnt == CNT_END) begin
          state_nx = ST_IDLE;
        end else begin
          bit_cnt_nx = bit_cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // One CRC unit: fed by cmd_in while receiving, by the response word while transmitting
  always_comb begin
    crc_clear = (state == ST_IDLE) || (state == ST_WAIT_RSP) || (state == ST_NCR);
    crc_shift = (state == ST_TX) && !in_body;
`ifdef SD_CMD_RSP_CRC_CHECK_EN
    crc_en  = ((state == ST_TX) || (state == ST_RX)) && in_body;
    crc_bit = (state == ST_TX) ? tx_sr[39] : cmd_in;
`else
    crc_en  = (state == ST_TX) && in_body;
    crc_bit = tx_sr[39];
`endif
  end

  sd_crc7 u_crc7 (
    .clk    (sd_clock),
    .rst    (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .shift  (crc_shift),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= rx_good;
      frame_err <= trans_bad || (rx_end && !cmd_in);
      if ((state == ST_RX) && (bit_cnt >= CNT_INDEX) && in_body) begin
        rx_sr <= {rx_sr[36:0], cmd_in};
      end
      if (rx_good) begin
        cmd_index <= rx_sr[37:32];
        cmd_arg   <= rx_sr[31:0];
      end
      if (rsp_take) begin
        tx_sr <= {1'b0, TRANS_CARD, rsp_index, rsp_arg};
      end else if ((state == ST_TX) && in_body) begin
        tx_sr <= {tx_sr[38:0], 1'b0};
      end
    end
  end

`ifdef SD_CMD_RSP_CRC_CHECK_EN
  logic [6:0] rx_crc;

  // Received CRC field is held aside and compared once the end bit is seen
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      rx_crc  <= '0;
      crc_err <= 1'b0;
    end else begin
      if ((state == ST_RX) && !in_body && (bit_cnt != CNT_END)) begin
        rx_crc <= {rx_crc[5:0], cmd_in};
      end
      crc_err <= rx_good && (rx_crc != crc);
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb/tb_sd_cmd_responder.sv - directed table-driven bench for sd_cmd_responder
module tb_sd_cmd_responder;

  localparam int NCR = 2;

`ifdef SD_CMD_RSP_CRC_CHECK_EN
  localparam logic BAD_CRC_EXP = 1'b1;
`else
  localparam logic BAD_CRC_EXP = 1'b0;
`endif

  logic        sd_clock = 1'b0;
  logic        reset, cmd_in, rsp_valid, rsp_drop;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;
  logic        cmd_out, cmd_oe, cmd_valid, crc_err, frame_err, rsp_ready, busy;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int oe_seen = 0;

  sd_cmd_responder #(.NCR_CYCLES(NCR), .CNT_W(6)) dut (
    .sd_clock  (sd_clock),
    .reset     (reset),
    .cmd_in    (cmd_in),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_index (rsp_index),
    .rsp_arg   (rsp_arg),
    .rsp_drop  (rsp_drop),
    .busy      (busy)
  );

  always #5 sd_clock = ~sd_clock;

  always @(negedge sd_clock) begin
    if (cmd_valid) valid_seen++;
    if (cmd_oe) oe_seen++;
  end

  typedef struct {
    string       name;
    logic [47:0] frame;
    logic        exp_valid;
    logic        exp_ferr;
    logic        exp_crc_err;
    logic [5:0]  exp_index;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives the top n bits of f, one per clock, then idles the line high;
  // returns just after the clock that sampled the last bit
  task automatic send_bits(input logic [47:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sd_clock);
      cmd_in = f[47-i];
    end
    @(negedge sd_clock);
    cmd_in = 1'b1;
    #1;
  endtask

  task automatic wait_oe(input string nm, output int n);
    n = 0;
    do begin
      @(negedge sd_clock);
      rsp_valid = 1'b0;
      #1;
      n++;
    end while (!cmd_oe && n < 100);
    if (!cmd_oe) begin
      checks++;
      errors++;
      $display("FAIL %s: cmd_oe never rose within 100 clocks", nm);
    end
  endtask

  initial begin
    int          v0, oe0, n;
    logic [47:0] word, exp_word;

    vecs[0] = '{"cmd8",     48'h48_0000_01AA_87, 1'b1, 1'b0, 1'b0, 6'd8, 32'h0000_01AA};
    vecs[1] = '{"end0",     mk_frame(6'd55, 32'h1234_5678) & ~48'h1,
                1'b0, 1'b1, 1'b0, 6'd8, 32'h0000_01AA};
    vecs[2] = '{"cmd17bad", 48'h51_0000_0000_57, 1'b1, 1'b0, BAD_CRC_EXP, 6'd17, 32'h0};
    vecs[3] = '{"cmd55",    mk_frame(6'd55, 32'hDEAD_BEEF), 1'b1, 1'b0, 1'b0, 6'd55, 32'hDEAD_BEEF};
    vecs[4] = '{"cmd0",     48'h40_0000_0000_95, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};

    reset = 1'b1; cmd_in = 1'b1; rsp_valid = 1'b0; rsp_drop = 1'b0;
    rsp_index = '0; rsp_arg = '0;
    #1;
    chk("rst.cmd_out", cmd_out, 1);
    chk("rst.cmd_oe", cmd_oe, 0);
    chk("rst.cmd_valid", cmd_valid, 0);
    chk("rst.crc_err", crc_err, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.rsp_ready", rsp_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cmd_index", cmd_index, 0);
    chk("rst.cmd_arg", cmd_arg, 0);
    repeat (2) @(negedge sd_clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      v0 = valid_seen;
      send_bits(vecs[i].frame, 48);
      chk($sformatf("%s.valid", vecs[i].name), cmd_valid, vecs[i].exp_valid);
      chk($sformatf("%s.frame_err", vecs[i].name), frame_err, vecs[i].exp_ferr);
      chk($sformatf("%s.index", vecs[i].name), cmd_index, vecs[i].exp_index);
      chk($sformatf("%s.arg", vecs[i].name), cmd_arg, vecs[i].exp_arg);
      if (vecs[i].exp_valid) chk($sformatf("%s.crc_err", vecs[i].name), crc_err, vecs[i].exp_crc_err);
      @(negedge sd_clock);
      #1;
      chk($sformatf("%s.pulse_end", vecs[i].name), {cmd_valid, frame_err}, 2'b00);
      chk($sformatf("%s.valid_count", vecs[i].name), valid_seen - v0, vecs[i].exp_valid);
      chk($sformatf("%s.rsp_ready", vecs[i].name), rsp_ready, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        rsp_drop = 1'b1;
        @(negedge sd_clock);
        rsp_drop = 1'b0;
        #1;
      end
      chk($sformatf("%s.idle", vecs[i].name), busy, 0);
    end
    chk("table.no_oe", oe_seen, 0);

    // CMD8 with R7 response
    send_bits(48'h48_0000_01AA_87, 48);
    chk("r7.valid", cmd_valid, 1);
    rsp_index = 6'd8; rsp_arg = 32'h0000_01AA; rsp_valid = 1'b1;
    chk("r7.ready", rsp_ready, 1);
    wait_oe("r7.oe_wait", n);
    chk("r7.oe_latency", n, NCR + 1);
    word = '0;
    word[47] = cmd_out;
    oe0 = oe_seen;
    for (int b = 46; b >= 0; b--) begin
      @(negedge sd_clock);
      #1;
      word[b] = cmd_out;
    end
    chk("r7.oe_cycles", oe_seen - oe0 + 1, 48);
    exp_word = {2'b00, 6'd8, 32'h0000_01AA, crc7({2'b00, 6'd8, 32'h0000_01AA}), 1'b1};
    chk("r7.word", word, exp_word);
    @(negedge sd_clock);
    #1;
    chk("r7.oe_fall", cmd_oe, 0);
    chk("r7.idle", busy, 0);
    chk("r7.line_idle", cmd_out, 1);

    // Transmission bit 0 aborts the frame; previous command fields remain
    v0 = valid_seen;
    send_bits(48'h0, 2);
    chk("trans0.frame_err", frame_err, 1);
    chk("trans0.index", cmd_index, 8);
    chk("trans0.arg", cmd_arg, 32'h0000_01AA);
    repeat (50) @(negedge sd_clock);
    #1;
    chk("trans0.no_valid", valid_seen - v0, 0);
    chk("trans0.idle", busy, 0);

    // New start bit while waiting for a response restarts reception
    send_bits(48'h40_0000_0000_95, 48);
    chk("restart.first", cmd_valid, 1);
    send_bits(mk_frame(6'd2, 32'hA5A5_0F0F), 48);
    chk("restart.second", cmd_valid, 1);
    chk("restart.index", cmd_index, 2);
    chk("restart.arg", cmd_arg, 32'hA5A5_0F0F);
    oe0 = oe_seen;
    rsp_drop = 1'b1; rsp_valid = 1'b1;
    @(negedge sd_clock);
    rsp_drop = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("drop_wins.idle", busy, 0);
    repeat (NCR + 5) @(negedge sd_clock);
    #1;
    chk("drop_wins.no_oe", oe_seen - oe0, 0);

    // Reset in the middle of a response
    send_bits(48'h48_0000_01AA_87, 48);
    rsp_valid = 1'b1;
    wait_oe("rst_tx.oe_wait", n);
    repeat (20) @(negedge sd_clock);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_tx.oe", cmd_oe, 0);
    chk("rst_tx.out", cmd_out, 1);
    chk("rst_tx.busy", busy, 0);
    chk("rst_tx.index", cmd_index, 0);
    @(negedge sd_clock);
    reset = 1'b0;
    send_bits(48'h40_0000_0000_95, 48);
    chk("post_rst.valid", cmd_valid, 1);
    chk("post_rst.index", cmd_index, 0);
    chk("post_rst.arg", cmd_arg, 0);
    chk("post_rst.crc_err", crc_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
